// File: rtl/dma_write.sv
// SD-card write DMA: streams 1-15 consecutive 512-byte sectors from memory to the
// shared SPI master using the SD data phase (token, data, dummy CRC, response, busy).
module dma_write #(
  parameter logic [7:0]  TOKEN      = 8'hFE,
  parameter logic [7:0]  RESP_POLL  = 8'd8,
  parameter logic [15:0] BUSY_LIMIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] iaddr,
  input  logic [3:0]  nblocks,
  output logic [15:0] oaddr,
  input  logic [7:0]  idata,
  output logic        ready,
  output logic [7:0]  ospi_data,
  output logic        ospi_wr,
  input  logic [7:0]  ispi_data,
  input  logic        ispi_dsr,
  output logic        oerror,
  output logic [7:0]  ostatus,
  output logic [7:0]  debug
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_TOKEN = 4'd1,
    S_FETCH = 4'd2,
    S_DATA  = 4'd3,
    S_CRC   = 4'd4,
    S_RESP  = 4'd5,
    S_BUSY  = 4'd6
  } state_e;

  // Every byte send walks issue -> skip one ce cycle -> wait for dsr.
  typedef enum logic [1:0] {
    P_ISSUE = 2'd0,
    P_SKIP  = 2'd1,
    P_WAIT  = 2'd2
  } phase_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] oaddr_q, oaddr_d;
  logic [9:0]  idx_q, idx_d;
  logic [7:0]  poll_q, poll_d;
  logic [15:0] busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        oerror_q, oerror_d;
  logic [7:0]  ostatus_q, ostatus_d;
  logic [7:0]  spi_data_q, spi_data_d;
  logic        spi_wr_q, spi_wr_d;
  logic        is_send_s;
  logic        done_s;
  logic [7:0]  send_byte_s;

  // Byte to transmit in the current state.
  always_comb begin
    is_send_s   = 1'b0;
    send_byte_s = 8'hFF;
    case (state_q)
      S_TOKEN: begin
        is_send_s   = 1'b1;
        send_byte_s = TOKEN;
      end
      S_DATA: begin
        is_send_s   = 1'b1;
        send_byte_s = idata;
      end
      S_CRC, S_RESP, S_BUSY: begin
        is_send_s   = 1'b1;
        send_byte_s = 8'hFF;
      end
      default: begin
        is_send_s   = 1'b0;
        send_byte_s = 8'hFF;
      end
    endcase
  end

  // SPI send sub-phase: one-clk strobe, then completion when dsr returns.
  always_comb begin
    phase_d    = phase_q;
    spi_wr_d   = 1'b0;
    spi_data_d = spi_data_q;
    done_s     = 1'b0;
    if (ce && is_send_s) begin
      case (phase_q)
        P_ISSUE: begin
          spi_wr_d   = 1'b1;
          spi_data_d = send_byte_s;
          phase_d    = P_SKIP;
        end
        P_SKIP: phase_d = P_WAIT;
        P_WAIT: begin
          if (ispi_dsr) begin
            done_s  = 1'b1;
            phase_d = P_ISSUE;
          end else begin
            phase_d = P_WAIT;
          end
        end
        default: phase_d = P_ISSUE;
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Sector sequencing, response/busy handling and status.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    oaddr_d   = oaddr_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    oerror_d  = oerror_q;
    ostatus_d = ostatus_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (nblocks != 4'd0) begin
            cnt_d    = nblocks;
            addr_d   = iaddr;
            oerror_d = 1'b0;
            ready_d  = 1'b0;
            state_d  = S_TOKEN;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TOKEN: begin
          if (done_s) begin
            idx_d   = 10'd0;
            oaddr_d = addr_q;
            state_d = S_FETCH;
          end else begin
            state_d = S_TOKEN;
          end
        end
        S_FETCH: state_d = S_DATA;
        S_DATA: begin
          if (done_s) begin
            addr_d = addr_q + 16'd1;
            // oaddr keeps the last byte read once the sector is complete
            if (idx_q == 10'd511) begin
              idx_d   = 10'd0;
              state_d = S_CRC;
            end else begin
              idx_d   = idx_q + 10'd1;
              oaddr_d = addr_q + 16'd1;
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_CRC: begin
          if (done_s) begin
            if (idx_q[0]) begin
              poll_d  = 8'd0;
              state_d = S_RESP;
            end else begin
              idx_d = 10'd1;
            end
          end else begin
            state_d = S_CRC;
          end
        end
        S_RESP: begin
          if (done_s) begin
            if (ispi_data == 8'hFF) begin
              if (poll_q == RESP_POLL - 8'd1) begin
                oerror_d  = 1'b1;
                ostatus_d = 8'hFF;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
              end else begin
                poll_d = poll_q + 8'd1;
              end
            end else begin
              ostatus_d = ispi_data;
              if (ispi_data[4:0] == 5'h05) begin
                busy_d  = 16'd0;
                state_d = S_BUSY;
              end else begin
                oerror_d = 1'b1;
                ready_d  = 1'b1;
                state_d  = S_IDLE;
              end
            end
          end else begin
            state_d = S_RESP;
          end
        end
        S_BUSY: begin
          if (done_s) begin
            if (ispi_data == 8'hFF) begin
              cnt_d = cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin
                ready_d = 1'b1;
                state_d = S_IDLE;
              end else begin
                state_d = S_TOKEN;
              end
            end else if (busy_q == BUSY_LIMIT - 16'd1) begin
              oerror_d  = 1'b1;
              ostatus_d = 8'hEE;
              ready_d   = 1'b1;
              state_d   = S_IDLE;
            end else begin
              busy_d = busy_q + 16'd1;
            end
          end else begin
            state_d = S_BUSY;
          end
        end
        default: begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      phase_q    <= P_ISSUE;
      cnt_q      <= 4'd0;
      addr_q     <= 16'd0;
      oaddr_q    <= 16'd0;
      idx_q      <= 10'd0;
      poll_q     <= 8'd0;
      busy_q     <= 16'd0;
      ready_q    <= 1'b1;
      oerror_q   <= 1'b0;
      ostatus_q  <= 8'd0;
      spi_data_q <= 8'hFF;
      spi_wr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      oaddr_q    <= oaddr_d;
      idx_q      <= idx_d;
      poll_q     <= poll_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      oerror_q   <= oerror_d;
      ostatus_q  <= ostatus_d;
      spi_data_q <= spi_data_d;
      spi_wr_q   <= spi_wr_d;
    end
  end

  assign oaddr     = oaddr_q;
  assign ready     = ready_q;
  assign ospi_data = spi_data_q;
  assign ospi_wr   = spi_wr_q;
  assign oerror    = oerror_q;
  assign ostatus   = ostatus_q;
  assign debug     = {ready_q, oerror_q, 2'b00, state_q};

endmodule

// File: tb/tb_dma_write.sv
// Scoreboard bench for dma_write: expected SPI bytes and memory read addresses are
// queued by the stimulus; a negedge monitor pops and compares every strobe and fetch.
module tb_dma_write;

  localparam int BYTE_T = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [15:0] iaddr;
  logic [3:0]  nblocks;
  logic [15:0] oaddr;
  logic [7:0]  idata = 8'h00;
  logic        ready;
  logic [7:0]  ospi_data;
  logic        ospi_wr;
  logic [7:0]  ispi_data;
  logic        ispi_dsr;
  logic        oerror;
  logic [7:0]  ostatus;
  logic [7:0]  debug;

  int checks = 0;
  int errors = 0;
  int strobes_seen = 0;
  logic ce_mode = 1'b0;

  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];
  logic [8:0]  miso_q[$];

  dma_write dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .iaddr(iaddr), .nblocks(nblocks),
    .oaddr(oaddr), .idata(idata), .ready(ready), .ospi_data(ospi_data),
    .ospi_wr(ospi_wr), .ispi_data(ispi_data), .ispi_dsr(ispi_dsr),
    .oerror(oerror), .ostatus(ostatus), .debug(debug)
  );

  always #5 clk = ~clk;

  // one-ce-cycle-latency memory whose content is the low address byte
  always @(posedge clk) begin
    if (ce) idata <= oaddr[7:0];
  end

  // SPI master model: bytes 0..514 of a block answer FF, later ones come from miso_q
  int tmr;
  int pos;
  logic [7:0] pend;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ispi_dsr  <= 1'b1;
      ispi_data <= 8'hFF;
      tmr       <= 0;
      pos       <= 0;
      pend      <= 8'hFF;
    end else if (ospi_wr) begin
      ispi_dsr <= 1'b0;
      tmr      <= BYTE_T;
      if (pos >= 515 && miso_q.size() != 0) begin
        pend <= miso_q[0][7:0];
        pos  <= miso_q[0][8] ? 0 : pos + 1;
        miso_q.delete(0);
      end else begin
        pend <= 8'hFF;
        pos  <= pos + 1;
      end
    end else if (tmr != 0) begin
      tmr <= tmr - 1;
      if (tmr == 1) begin
        ispi_dsr  <= 1'b1;
        ispi_data <= pend;
      end
    end else if (ready) begin
      pos <= 0;
    end
  end

  initial begin : ce_gen
    int ph;
    ph = 0;
    ce = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ce_mode) begin
        ph = (ph == 2) ? 0 : ph + 1;
        ce = (ph == 0);
      end else begin
        ce = 1'b1;
      end
    end
  end

  initial begin : monitor
    logic prev_rst, prev_ce, prev_wr;
    logic [7:0] prev_dbg, eb;
    logic [15:0] prev_addr, ea;
    prev_rst = 1'b0; prev_ce = 1'b1; prev_wr = 1'b0; prev_dbg = 8'h00; prev_addr = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset_n && prev_rst) begin
        if (ospi_wr) begin
          strobes_seen++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spi_byte: unexpected strobe with %02h, no byte required", ospi_data);
          end else begin
            eb = exp_q.pop_front();
            if (ospi_data !== eb) begin
              errors++;
              $display("FAIL spi_byte #%0d: got %02h required %02h", strobes_seen, ospi_data, eb);
            end
          end
          checks++;
          if (prev_wr || ready || !ispi_dsr) begin
            errors++;
            $display("FAIL spi_strobe: prev_wr=%b ready=%b dsr=%b required 0 0 1", prev_wr, ready, ispi_dsr);
          end
        end
        if (ce && debug[3:0] == 4'd2) begin
          checks++;
          if (exp_addr_q.size() == 0) begin
            errors++;
            $display("FAIL mem_read: unexpected read of %04h", oaddr);
          end else begin
            ea = exp_addr_q.pop_front();
            if (oaddr !== ea) begin
              errors++;
              $display("FAIL mem_read: got %04h required %04h", oaddr, ea);
            end
          end
        end
        if (!prev_ce) begin
          checks++;
          if (debug !== prev_dbg || oaddr !== prev_addr) begin
            errors++;
            $display("FAIL ce_hold: debug %02h oaddr %04h required %02h %04h", debug, oaddr, prev_dbg, prev_addr);
          end
        end
      end
      prev_rst = reset_n; prev_ce = ce; prev_wr = ospi_wr; prev_dbg = debug; prev_addr = oaddr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic push_data(input logic [15:0] base, input int n);
    logic [15:0] a;
    for (int i = 0; i < n; i++) begin
      a = base + i[15:0];
      exp_q.push_back(a[7:0]);
      exp_addr_q.push_back(a);
    end
  endtask

  task automatic push_block(input logic [15:0] base);
    exp_q.push_back(8'hFE);
    push_data(base, 512);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
  endtask

  task automatic push_ff(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(8'hFF);
  endtask

  task automatic miso(input logic [7:0] b, input logic last);
    miso_q.push_back({last, b});
  endtask

  task automatic start(input logic [15:0] a, input logic [3:0] n);
    int k;
    iaddr = a;
    nblocks = n;
    k = 0;
    while (ready === 1'b1 && k < 50) begin tick(); k++; end
    chk("start_ready_low", {15'd0, ready}, 16'd0);
    nblocks = 4'd0;
  endtask

  task automatic run_xfer(input logic [15:0] a, input logic [3:0] n);
    int k;
    start(a, n);
    k = 0;
    while (ready !== 1'b1 && k < 60000) begin tick(); k++; end
    chk("done_ready", {15'd0, ready}, 16'd1);
    repeat (40) tick();
    chk("bytes_left", exp_q.size(), 16'd0);
    chk("reads_left", exp_addr_q.size(), 16'd0);
    exp_q.delete();
    exp_addr_q.delete();
    miso_q.delete();
  endtask

  initial begin : stim
    int k, base;
    reset_n = 1'b0; iaddr = 16'h0000; nblocks = 4'd0;
    repeat (3) tick();
    chk("rst_ready", {15'd0, ready}, 16'd1);
    chk("rst_oaddr", oaddr, 16'h0000);
    chk("rst_wr", {15'd0, ospi_wr}, 16'd0);
    chk("rst_spi_data", {8'd0, ospi_data}, 16'h00FF);
    chk("rst_status", {7'd0, oerror, ostatus}, 16'h0000);
    chk("rst_debug", {8'd0, debug}, 16'h0080);
    reset_n = 1'b1;
    repeat (2) tick();

    push_block(16'h0200); push_ff(4);
    miso(8'hE5, 1'b0); miso(8'h00, 1'b0); miso(8'h00, 1'b0); miso(8'hFF, 1'b1);
    run_xfer(16'h0200, 4'd1);
    chk("single_err", {15'd0, oerror}, 16'd0);
    chk("single_status", {8'd0, ostatus}, 16'h00E5);
    chk("single_oaddr", oaddr, 16'h03FF);

    for (int b = 0; b < 3; b++) begin
      push_block(16'h0800 + 16'(b * 512)); push_ff(3);
      miso(8'hE5, 1'b0); miso(8'h00, 1'b0); miso(8'hFF, 1'b1);
    end
    run_xfer(16'h0800, 4'd3);
    chk("multi_err", {15'd0, oerror}, 16'd0);
    chk("multi_oaddr", oaddr, 16'h0DFF);

    push_block(16'h3000); push_ff(1);
    miso(8'h0B, 1'b1);
    run_xfer(16'h3000, 4'd2);
    chk("wrerr_err", {15'd0, oerror}, 16'd1);
    chk("wrerr_status", {8'd0, ostatus}, 16'h000B);

    push_block(16'h4000); push_ff(8);
    run_xfer(16'h4000, 4'd1);
    chk("resp_to_err", {15'd0, oerror}, 16'd1);
    chk("resp_to_status", {8'd0, ostatus}, 16'h00FF);

    push_block(16'hFF00); push_ff(2);
    miso(8'hE5, 1'b0); miso(8'hFF, 1'b1);
    run_xfer(16'hFF00, 4'd1);
    chk("wrap_err", {15'd0, oerror}, 16'd0);
    chk("wrap_oaddr", oaddr, 16'h00FF);

    exp_q.push_back(8'hFE);
    push_data(16'h5000, 100);
    base = strobes_seen;
    start(16'h5000, 4'd1);
    k = 0;
    while (strobes_seen < base + 101 && k < 5000) begin tick(); k++; end
    chk("mid_strobes", 16'(strobes_seen - base), 16'd101);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", {15'd0, ready}, 16'd1);
    chk("mid_rst_wr", {15'd0, ospi_wr}, 16'd0);
    chk("mid_rst_debug", {8'd0, debug}, 16'h0080);
    exp_q.delete(); exp_addr_q.delete(); miso_q.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    push_block(16'h1000); push_ff(2);
    miso(8'hE5, 1'b0); miso(8'hFF, 1'b1);
    run_xfer(16'h1000, 4'd1);
    chk("restart_status", {7'd0, oerror, ostatus}, 16'h00E5);
    chk("restart_oaddr", oaddr, 16'h11FF);

    ce_mode = 1'b1;
    push_block(16'h0200); push_ff(4);
    miso(8'hE5, 1'b0); miso(8'h00, 1'b0); miso(8'h00, 1'b0); miso(8'hFF, 1'b1);
    run_xfer(16'h0200, 4'd1);
    chk("ce_status", {7'd0, oerror, ostatus}, 16'h00E5);
    chk("ce_oaddr", oaddr, 16'h03FF);
    ce_mode = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
